// File: rtl/fetch_unit.sv
// Instruction fetch stage: IDLE/FETCH/VALID handshake between imem and decode.
// Optional FETCH_STALLCNT_EN adds a saturating count of decode back-pressure cycles.
module fetch_unit #(
  parameter int PC_W   = 7,
  parameter int INST_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [PC_W-1:0]   pc_cur,
  output logic [PC_W-1:0]   pc_next,
  output logic              imem_req,
  output logic [PC_W-3:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
`ifdef FETCH_STALLCNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, VALID} state_t;
  state_t state;

  logic [PC_W-1:0] redir_tgt;
  assign redir_tgt = redirect_pc & ~PC_W'(3);

  assign imem_req   = (state == FETCH) && !redirect;
  assign imem_addr  = pc_cur[PC_W-1:2];
  assign inst_valid = (state == VALID);

  // pc_next is forced to zero during reset so the program counter restarts at 0.
  always_comb begin
    pc_next = pc_cur;
    if (!reset_n)
      pc_next = '0;
    else if (redirect)
      pc_next = redir_tgt;
    else if (state == FETCH && imem_ack)
      pc_next = pc_cur + PC_W'(4);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      inst    <= '0;
      inst_pc <= '0;
    end else begin
      case (state)
        IDLE:  state <= FETCH;
        FETCH: begin
          // a coincident redirect discards the returning data
          if (imem_ack && !redirect) begin
            state   <= VALID;
            inst    <= imem_rdata;
            inst_pc <= pc_cur;
          end
        end
        VALID: if (inst_ready || redirect) state <= FETCH;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_STALLCNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_cnt <= '0;
    else if (state == VALID && !inst_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit; the bench owns the program counter
// and the instruction memory and predicts every output from a cycle-level model.
module tb_fetch_unit;
  logic        clk = 0;
  logic        reset_n = 0;
  logic [6:0]  pc_cur = '0;
  logic [6:0]  pc_next;
  logic        imem_req;
  logic [4:0]  imem_addr;
  logic        imem_ack = 0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic [6:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready = 0;
  logic        redirect = 0;
  logic [6:0]  redirect_pc = '0;
`ifdef FETCH_STALLCNT_EN
  logic [15:0] stall_cnt;
`endif

  fetch_unit #(.PC_W(7), .INST_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .pc_cur(pc_cur), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_STALLCNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // reference: "started" = left reset idle cycle, "hold" = an instruction is waiting for decode
  logic [31:0] mem [32];
  bit          m_started, m_hold;
  logic [6:0]  m_pc, m_ipc;
  logic [31:0] m_inst;
  int          m_stall;
  logic [6:0]  last_pcn;
  logic [31:0] got_inst[$];
  logic [6:0]  got_pc[$];

  task automatic model_reset();
    m_started = 0; m_hold = 0; m_pc = '0; m_ipc = '0; m_inst = '0; m_stall = 0;
  endtask

  task automatic step(input bit ack, input bit rdy, input bit rd, input logic [6:0] rpc);
    bit fetching;
    logic [6:0] exp_pcn;
    imem_ack = ack; inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    pc_cur = m_pc; imem_rdata = mem[m_pc[6:2]];
    #2;
    fetching = m_started && !m_hold;
    exp_pcn  = rd ? {rpc[6:2], 2'b00} : (fetching && ack) ? 7'(m_pc + 7'd4) : m_pc;
    chk("imem_req", imem_req, fetching && !rd);
    chk("imem_addr", imem_addr, m_pc[6:2]);
    chk("pc_next", pc_next, exp_pcn);
    chk("inst_valid", inst_valid, m_hold);
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
`ifdef FETCH_STALLCNT_EN
    chk("stall_cnt", stall_cnt, m_stall);
`endif
    last_pcn = pc_next;
    if (inst_valid && rdy) begin
      got_inst.push_back(inst);
      got_pc.push_back(inst_pc);
    end
    @(posedge clk);
    if (!m_started) m_started = 1;
    else if (!m_hold) begin
      if (ack && !rd) begin m_hold = 1; m_inst = imem_rdata; m_ipc = m_pc; end
    end else begin
      if (!rdy && m_stall < 65535) m_stall++;
      if (rd || rdy) m_hold = 0;
    end
    m_pc = exp_pcn;
    #1;
  endtask

  // asserts reset between edges, checks the immediate effect, releases off-edge
  task automatic do_reset();
    reset_n = 0;
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_pcn", pc_next, 7'd0);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 7'd0);
    model_reset();
    pc_cur = '0; imem_ack = 0; redirect = 0; inst_ready = 0;
    @(posedge clk); #2;
    reset_n = 1;
  endtask

  initial begin
    logic [31:0] cap;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'hA000_000A; mem[1] = 32'hB000_000B; mem[2] = 32'hC000_000C;
    do_reset();

    // A/B/C stream, ready always high, ack one cycle after each request
    step(0, 1, 0, 0);
    got_inst.delete(); got_pc.delete();
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 0);
      step(0, 1, 0, 0);
    end
    chk("abc_count", got_inst.size(), 3);
    if (got_inst.size() == 3) begin
      chk("inst_A", got_inst[0], 32'hA000_000A); chk("pc_A", got_pc[0], 7'd0);
      chk("inst_B", got_inst[1], 32'hB000_000B); chk("pc_B", got_pc[1], 7'd4);
      chk("inst_C", got_inst[2], 32'hC000_000C); chk("pc_C", got_pc[2], 7'd8);
    end

    // PC wrap: ack at pc 124
    m_pc = 7'd124;
    step(1, 1, 0, 0);
    chk("wrap_pcn", last_pcn, 7'd0);
    step(0, 1, 0, 0);

    // redirect coinciding with ack in FETCH
    cap = inst;
    step(1, 1, 1, 7'd42);
    chk("redir_pcn", last_pcn, 7'd40);
    chk("redir_novalid", inst_valid, 1'b0);
    chk("redir_inst", inst, cap);
    step(0, 1, 0, 0);

    // 5-cycle stall from a fresh reset
    do_reset();
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    cap = inst;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk("stall_pcn", last_pcn, pc_cur);
    end
    chk("stall_inst", inst, cap);
    chk("stall_inst_pc", inst_pc, 7'd0);
`ifdef FETCH_STALLCNT_EN
    chk("stall_5", stall_cnt, 16'd5);
`endif
    // ack while VALID is ignored
    mem[1] = 32'h1234_5678;
    step(1, 0, 0, 0);
    chk("ack_valid_inst", inst, cap);
    chk("ack_valid_hold", inst_valid, 1'b1);

    // reset in the middle of a VALID cycle
    inst_ready = 0;
    #3;
    do_reset();

    // ack during the IDLE cycle is ignored
    step(1, 1, 0, 0);
    chk("ack_idle_inst", inst, 32'd0);
    chk("ack_idle_valid", inst_valid, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom_range(1, 0) == 1, $urandom_range(9, 0) < 6,
           $urandom_range(9, 0) == 0, 7'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL expose parameter PC_W, default 7, byte-address PC width (32 words x 4 bytes).
REQ-002 The block SHALL expose parameter INST_W, default 32, instruction width.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port pc_cur  input  PC_W  current PC from the program counter.
REQ-006 The block SHALL have port pc_next  output  PC_W  next PC, driven into the program counter's pc_in.
REQ-007 The block SHALL have port imem_req  output  1  instruction-memory read request.
REQ-008 The block SHALL have port imem_addr  output  PC_W-2  word address, equal to pc_cur[PC_W-1:2].
REQ-009 The block SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-010 The block SHALL have port imem_rdata  input  INST_W  read data.
REQ-011 The block SHALL have port inst  output  INST_W  fetched instruction to decode.
REQ-012 The block SHALL have port inst_pc  output  PC_W  PC of inst.
REQ-013 The block SHALL have port inst_valid  output  1  inst holds a valid instruction.
REQ-014 The block SHALL have port inst_ready  input  1  decode accepts inst this cycle.
REQ-015 The block SHALL have port redirect  input  1  taken branch/jump, asserted for one cycle.
REQ-016 The block SHALL have port redirect_pc  input  PC_W  redirect target.

Function
REQ-017 The block SHALL implement FSM states IDLE, FETCH and VALID.
REQ-018 Transitions SHALL be: IDLE->FETCH unconditionally; FETCH->VALID on imem_ack; VALID->FETCH on inst_ready; otherwise the state holds.
REQ-019 imem_req SHALL be 1 exactly when state is FETCH and redirect is 0.
REQ-020 On the FETCH-state imem_ack cycle the block SHALL register inst<=imem_rdata and inst_pc<=pc_cur.
REQ-021 pc_next SHALL follow this priority: redirect -> {redirect_pc[PC_W-1:2],2'b00}; FETCH and imem_ack -> pc_cur+4 modulo 2^PC_W (124+4 wraps to 0 at PC_W=7); otherwise -> pc_cur (hold).
REQ-022 inst_valid SHALL be 1 exactly when state is VALID.
REQ-023 inst and inst_pc SHALL stay stable while inst_valid=1 and inst_ready=0.
REQ-024 A transfer SHALL occur only on a cycle with inst_valid=1 and inst_ready=1; inst_ready is ignored in all other states.
REQ-025 On redirect=1 in any non-IDLE state, the next state SHALL be FETCH, inst_valid SHALL be 0 from the next cycle, and the held instruction SHALL be dropped.
REQ-026 When redirect and imem_ack coincide in FETCH, redirect SHALL win: the ack data is discarded, inst is not updated, and pc_next=redirect target.
REQ-027 When redirect and inst_ready coincide in VALID, the transfer SHALL complete and the redirect SHALL also take effect.
REQ-028 Fetch latency SHALL be: imem_ack in cycle N -> inst_valid=1 in cycle N+1; minimum fetch-to-fetch spacing is 2 cycles.
REQ-029 imem_ack outside FETCH SHALL be ignored.

Reset
REQ-030 While reset_n=0, the block SHALL hold: state IDLE, inst=0, inst_pc=0, inst_valid=0, imem_req=0, pc_next=0.
REQ-031 Reset assertion SHALL take effect immediately, without a clock edge; reset mid-fetch SHALL abandon the fetch with no further outputs.
REQ-032 After reset_n rises, the block SHALL spend one cycle in IDLE, then enter FETCH at pc_cur=0.

Configuration
REQ-033 With macro FETCH_STALLCNT_EN defined, the block SHALL add output stall_cnt (16 bits), reset to 0, incrementing each cycle with inst_valid=1 and inst_ready=0, and saturating at 16'hFFFF.
REQ-034 With FETCH_STALLCNT_EN undefined, the stall_cnt port and its logic SHALL be absent, with no other behavioural change.

Verification
REQ-035 The bench SHALL cover: reset release, inst_ready=1, imem_ack one cycle after each req, mem[0..2]=A,B,C -> inst A/B/C with inst_pc 0/4/8, one inst_valid pulse every 2 cycles.
REQ-036 The bench SHALL cover: ack at pc_cur=124 -> pc_next=0 (wrap).
REQ-037 The bench SHALL cover: inst_ready=0 for 5 cycles in VALID -> inst/inst_pc stable, pc_next=pc_cur, stall_cnt=5 when FETCH_STALLCNT_EN is defined.
REQ-038 The bench SHALL cover: redirect=1 with redirect_pc=7'd42 coinciding with imem_ack -> pc_next=40, inst unchanged, next state FETCH, no inst_valid.
REQ-039 The bench SHALL cover: reset_n=0 asserted mid-VALID between clock edges -> inst_valid=0 and pc_next=0 immediately.
REQ-040 The bench SHALL cover: imem_ack pulsed in IDLE/VALID -> no state or data change.
